// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared constants and FSM state encoding for the instruction
// prefetch queue (fetch_queue, byte_fifo, fetch_queue_if).
package fetch_pkg;
   localparam int PC_WIDTH   = 16;
   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory read handshake plus the dispatch-side view of the
// prefetch queue.
//   master : the fetch_queue itself (drives MEM_ADDR/MEM_REQ, queue heads,
//            LEVEL, POP_ERR, FETCH_COUNT).
//   slave  : memory + dispatch logic (drives MEM_ACK/MEM_DATA, pops,
//            LOAD_PC/PC_IN, HALT).
interface fetch_queue_if import fetch_pkg::*; #(
   parameter int DEPTH = 4
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic [PC_WIDTH-1:0]   MEM_ADDR;
   logic                  MEM_REQ;
   logic                  MEM_ACK;
   logic [DATA_WIDTH-1:0] MEM_DATA;
   logic [DATA_WIDTH-1:0] HEAD0;
   logic [DATA_WIDTH-1:0] HEAD1;
   logic [LW-1:0]         LEVEL;
   logic                  POP_ONE;
   logic                  POP_TWO;
   logic                  POP_ERR;
   logic                  LOAD_PC;
   logic [PC_WIDTH-1:0]   PC_IN;
   logic                  HALT;
   logic [15:0]           FETCH_COUNT;

   modport master (
      output MEM_ADDR, MEM_REQ, HEAD0, HEAD1, LEVEL, POP_ERR, FETCH_COUNT,
      input  MEM_ACK, MEM_DATA, POP_ONE, POP_TWO, LOAD_PC, PC_IN, HALT
   );

   modport slave (
      input  MEM_ADDR, MEM_REQ, HEAD0, HEAD1, LEVEL, POP_ERR, FETCH_COUNT,
      output MEM_ACK, MEM_DATA, POP_ONE, POP_TWO, LOAD_PC, PC_IN, HALT
   );
endinterface

// File: rtl/fetch_queue_byte_fifo.sv
// byte_fifo: synchronous circular byte buffer that can drop one or two bytes
// per cycle from the head.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : append din at the tail
//   pop1 / pop2   : drop one / two head bytes (caller guarantees legality)
//   flush         : empty the buffer (wins over push/pop)
//   level         : bytes held
//   head0, head1  : oldest / second-oldest byte, 8'h00 when that slot is empty
module byte_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop1,
   input  logic                  pop2,
   input  logic                  flush,
   output logic [LW-1:0]         level,
   output logic [DATA_WIDTH-1:0] head0,
   output logic [DATA_WIDTH-1:0] head1
);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [1:0]            npop;

   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      level_d = level_q;
      npop    = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         level_d = '0;
      end else begin
         // pointers wrap by natural overflow (DEPTH is a power of two)
         rd_d = rd_q + PW'(npop);
         if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + PW'(1);
         end
         level_d = level_q + LW'(push) - LW'(npop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
         mem_q   <= mem_d;
      end
   end

   assign level = level_q;
   assign head0 = (level_q >= LW'(1)) ? mem_q[rd_q] : '0;
   assign head1 = (level_q >= LW'(2)) ? mem_q[rd_q + PW'(1)] : '0;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer. Owns the program counter, issues
// one byte read at a time to program memory and queues the returned bytes
// for dispatch, which consumes one or two bytes per instruction.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : fetch_queue_if.master (memory handshake, queue heads, LEVEL,
//              pops, LOAD_PC/PC_IN redirect, HALT, FETCH_COUNT)
// Optional: define FETCH_STATS_EN to count pushed bytes on FETCH_COUNT
// (saturating); otherwise FETCH_COUNT is constant zero.
module fetch_queue import fetch_pkg::*; #(
   parameter int                  DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000
) (
   input  logic          CLK,
   input  logic          RST,
   fetch_queue_if.master bus
);
   localparam int LW = $clog2(DEPTH) + 1;

   fetch_state_t          state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   addr_q, addr_d;
   logic                  pop_err_q, pop_err_d;
   logic                  push, flush, pop1, pop2;
   logic [1:0]            npop;
   logic [LW-1:0]         level, level_after_pop;
   logic [DATA_WIDTH-1:0] head0, head1;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      addr_d          = addr_q;
      pop_err_d       = 1'b0;
      push            = 1'b0;
      flush           = 1'b0;
      pop1            = 1'b0;
      pop2            = 1'b0;

      // pops: LOAD_PC swallows them silently; otherwise illegal ones flag
      if (bus.LOAD_PC) begin
         flush = 1'b1;
         pc_d  = bus.PC_IN;
      end else if (bus.POP_ONE || bus.POP_TWO) begin
         if ((bus.POP_ONE && bus.POP_TWO) ||
             (bus.POP_ONE && level < LW'(1)) ||
             (bus.POP_TWO && level < LW'(2))) begin
            pop_err_d = 1'b1;
         end else begin
            pop1 = bus.POP_ONE;
            pop2 = bus.POP_TWO;
         end
      end
      npop            = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
      level_after_pop = level - LW'(npop);

      case (state_q)
         IDLE: begin
            // only issue when the returning byte is guaranteed a slot;
            // a redirect waits one cycle so the fresh pc is used
            if (!bus.LOAD_PC && !bus.HALT && level_after_pop < LW'(DEPTH)) begin
               state_d = REQ;
               addr_d  = pc_q;
            end
         end
         REQ: begin
            if (bus.MEM_ACK) begin
               state_d = IDLE;
               if (!bus.LOAD_PC) begin
                  push = 1'b1;
                  pc_d = pc_q + 16'd1;
               end
            end else if (bus.LOAD_PC) begin
               // stale request still has to be retired before reissuing
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (bus.MEM_ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         pop_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         pop_err_q <= pop_err_d;
      end
   end

   byte_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .din   (bus.MEM_DATA),
      .pop1  (pop1),
      .pop2  (pop2),
      .flush (flush),
      .level (level),
      .head0 (head0),
      .head1 (head1)
   );

   assign bus.MEM_REQ  = (state_q != IDLE);
   assign bus.MEM_ADDR = addr_q;
   assign bus.HEAD0    = head0;
   assign bus.HEAD1    = head1;
   assign bus.LEVEL    = level;
   assign bus.POP_ERR  = pop_err_q;

`ifdef FETCH_STATS_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (push && count_q != 16'hFFFF) count_d = count_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end

   assign bus.FETCH_COUNT = count_q;
`else
   assign bus.FETCH_COUNT = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). Inputs change 1 time
// unit after the rising edge; outputs are checked at the same point.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   fetch_queue_if #(.DEPTH(4)) bus ();

   fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cexp(input int n);
`ifdef FETCH_STATS_EN
      return 16'(n);
`else
      return 16'h0000;
`endif
   endfunction

   // wait (bounded) for a request and check its address
   task automatic wait_req(input string tag, input logic [15:0] a);
      int n = 0;
      while (bus.MEM_REQ !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 32'(bus.MEM_REQ), 32'd1);
      chk({tag, "_addr"}, 32'(bus.MEM_ADDR), 32'(a));
   endtask

   // hold the request one cycle, then acknowledge with d
   task automatic serve(input logic [7:0] d);
      tick();
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = d;
      tick();
      bus.MEM_ACK  = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.MEM_ACK  = 1'b0;
      bus.MEM_DATA = 8'h00;
      bus.POP_ONE  = 1'b0;
      bus.POP_TWO  = 1'b0;
      bus.LOAD_PC  = 1'b0;
      bus.PC_IN    = 16'h0000;
      bus.HALT     = 1'b0;
      tick();
      tick();
      chk("rst_req",   32'(bus.MEM_REQ), 32'd0);
      chk("rst_addr",  32'(bus.MEM_ADDR), 32'h0000);
      chk("rst_level", 32'(bus.LEVEL), 32'd0);
      chk("rst_head0", 32'(bus.HEAD0), 32'h00);
      chk("rst_head1", 32'(bus.HEAD1), 32'h00);
      chk("rst_err",   32'(bus.POP_ERR), 32'd0);
      chk("rst_cnt",   32'(bus.FETCH_COUNT), 32'h0000);
      rst = 1'b0;

      // fill: addresses 0..3, data 0x10..0x13
      wait_req("f0", 16'h0000); serve(8'h10);
      wait_req("f1", 16'h0001); serve(8'h11);
      wait_req("f2", 16'h0002); serve(8'h12);
      wait_req("f3", 16'h0003); serve(8'h13);
      chk("full_level", 32'(bus.LEVEL), 32'd4);
      chk("full_head0", 32'(bus.HEAD0), 32'h10);
      chk("full_head1", 32'(bus.HEAD1), 32'h11);
      tick(); tick(); tick();
      chk("full_noreq", 32'(bus.MEM_REQ), 32'd0);
      chk("full_cnt",   32'(bus.FETCH_COUNT), 32'(cexp(4)));

      // pop two from full: request reissues in the same edge
      bus.POP_TWO = 1'b1;
      tick();
      bus.POP_TWO = 1'b0;
      chk("pop2_level", 32'(bus.LEVEL), 32'd2);
      chk("pop2_head0", 32'(bus.HEAD0), 32'h12);
      chk("pop2_head1", 32'(bus.HEAD1), 32'h13);
      wait_req("f4", 16'h0004); serve(8'h14);
      wait_req("f5", 16'h0005);
      chk("f5_level", 32'(bus.LEVEL), 32'd3);

      // redirect with request pending on 5; late ACK must be dropped
      bus.LOAD_PC = 1'b1;
      bus.PC_IN   = 16'h0100;
      tick();
      bus.LOAD_PC = 1'b0;
      chk("ld_level", 32'(bus.LEVEL), 32'd0);
      chk("ld_req",   32'(bus.MEM_REQ), 32'd1);
      chk("ld_addr",  32'(bus.MEM_ADDR), 32'h0005);
      serve(8'hEE);
      chk("disc_level", 32'(bus.LEVEL), 32'd0);
      chk("disc_head0", 32'(bus.HEAD0), 32'h00);
      chk("disc_req",   32'(bus.MEM_REQ), 32'd0);
      wait_req("f100", 16'h0100); serve(8'h20);
      chk("f100_head0", 32'(bus.HEAD0), 32'h20);

      // redirect from IDLE to 0xFFFF: pc wraps to 0
      bus.LOAD_PC = 1'b1;
      bus.PC_IN   = 16'hFFFF;
      tick();
      bus.LOAD_PC = 1'b0;
      chk("ld2_level", 32'(bus.LEVEL), 32'd0);
      chk("ld2_req",   32'(bus.MEM_REQ), 32'd0);
      wait_req("fffff", 16'hFFFF); serve(8'h30);
      wait_req("f0000", 16'h0000); serve(8'h31);
      bus.HALT = 1'b1;
      chk("wrap_level", 32'(bus.LEVEL), 32'd2);
      chk("wrap_head0", 32'(bus.HEAD0), 32'h30);
      chk("wrap_head1", 32'(bus.HEAD1), 32'h31);

      // pop errors at LEVEL=1 (halted so no requests interfere)
      bus.POP_ONE = 1'b1;
      tick();
      bus.POP_ONE = 1'b0;
      chk("pop1_level", 32'(bus.LEVEL), 32'd1);
      chk("pop1_head0", 32'(bus.HEAD0), 32'h31);
      chk("pop1_head1", 32'(bus.HEAD1), 32'h00);
      chk("pop1_err",   32'(bus.POP_ERR), 32'd0);
      bus.POP_TWO = 1'b1;
      tick();
      bus.POP_TWO = 1'b0;
      chk("err2_err",   32'(bus.POP_ERR), 32'd1);
      chk("err2_level", 32'(bus.LEVEL), 32'd1);
      chk("err2_head0", 32'(bus.HEAD0), 32'h31);
      tick();
      chk("err2_pulse", 32'(bus.POP_ERR), 32'd0);
      bus.POP_ONE = 1'b1;
      bus.POP_TWO = 1'b1;
      tick();
      bus.POP_ONE = 1'b0;
      bus.POP_TWO = 1'b0;
      chk("both_err",   32'(bus.POP_ERR), 32'd1);
      chk("both_level", 32'(bus.LEVEL), 32'd1);
      tick();
      chk("both_pulse", 32'(bus.POP_ERR), 32'd0);
      chk("halt_noreq", 32'(bus.MEM_REQ), 32'd0);

      // HALT raised while a request is pending: byte still lands
      bus.HALT = 1'b0;
      wait_req("f1b", 16'h0001);
      bus.HALT = 1'b1;
      serve(8'h40);
      chk("halt_level", 32'(bus.LEVEL), 32'd2);
      chk("halt_head1", 32'(bus.HEAD1), 32'h40);
      tick(); tick(); tick();
      chk("halt_req", 32'(bus.MEM_REQ), 32'd0);
      chk("halt_cnt", 32'(bus.FETCH_COUNT), 32'(cexp(9)));
      bus.HALT = 1'b0;
      wait_req("f2b", 16'h0002);

      // ACK and LOAD_PC in the same cycle: data discarded
      tick();
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = 8'h55;
      bus.LOAD_PC  = 1'b1;
      bus.PC_IN    = 16'h0200;
      tick();
      bus.MEM_ACK  = 1'b0;
      bus.LOAD_PC  = 1'b0;
      chk("ldack_level", 32'(bus.LEVEL), 32'd0);
      chk("ldack_req",   32'(bus.MEM_REQ), 32'd0);
      chk("ldack_cnt",   32'(bus.FETCH_COUNT), 32'(cexp(9)));
      wait_req("f200", 16'h0200); serve(8'h60);
      wait_req("f201", 16'h0201);

      // push and pop in the same cycle
      tick();
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = 8'h61;
      bus.POP_ONE  = 1'b1;
      tick();
      bus.MEM_ACK  = 1'b0;
      bus.POP_ONE  = 1'b0;
      chk("pp_level", 32'(bus.LEVEL), 32'd1);
      chk("pp_head0", 32'(bus.HEAD0), 32'h61);
      chk("pp_head1", 32'(bus.HEAD1), 32'h00);
      chk("pp_cnt",   32'(bus.FETCH_COUNT), 32'(cexp(11)));

      // reset mid-request; a stray ACK afterwards is ignored
      wait_req("f202", 16'h0202);
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      bus.HALT     = 1'b1;
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = 8'h77;
      tick();
      bus.MEM_ACK  = 1'b0;
      chk("rr_level", 32'(bus.LEVEL), 32'd0);
      chk("rr_req",   32'(bus.MEM_REQ), 32'd0);
      chk("rr_addr",  32'(bus.MEM_ADDR), 32'h0000);
      chk("rr_head0", 32'(bus.HEAD0), 32'h00);
      chk("rr_cnt",   32'(bus.FETCH_COUNT), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
